// File: rtl/bp_fpga_host_pkg.sv
// Shared types and constants for the fpga_host putchar stimulus generator:
// the send FSM state enum, a compact BedRock I/O message layout, the default
// putchar address and the default debounce length.
package bp_fpga_host_pkg;

    // Supported BP configurations (only the default one is modelled here)
    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [2:0] {
        e_reset = 3'd0,
        e_ready = 3'd1,
        e_send  = 3'd2,
        e_resp  = 3'd3
    } send_state_e;

    localparam int paddr_width_gp   = 40;
    localparam int io_data_width_gp = 64;
    localparam int io_payload_w_gp  = 16;

    localparam logic [63:0] putchar_base_addr_gp = 64'h0010_1000;
    localparam int          debounce_cycles_gp   = 1000000;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [3:0] {
        e_bedrock_store   = 4'd0,
        e_bedrock_amoswap = 4'd1,
        e_bedrock_amoadd  = 4'd2
    } bp_bedrock_subop_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1  = 3'd0,
        e_bedrock_msg_size_2  = 3'd1,
        e_bedrock_msg_size_4  = 3'd2,
        e_bedrock_msg_size_8  = 3'd3,
        e_bedrock_msg_size_16 = 3'd4,
        e_bedrock_msg_size_32 = 3'd5,
        e_bedrock_msg_size_64 = 3'd6
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        bp_bedrock_mem_type_e mem;
    } bp_bedrock_msg_type_s;

    typedef struct packed {
        logic [io_payload_w_gp-1:0] payload;
        bp_bedrock_subop_e          subop;
        logic [paddr_width_gp-1:0]  addr;
        bp_bedrock_msg_size_e       size;
        bp_bedrock_msg_type_s       msg_type;
    } bp_bedrock_io_mem_header_s;

    typedef struct packed {
        bp_bedrock_io_mem_header_s   header;
        logic [io_data_width_gp-1:0] data;
    } bp_bedrock_io_mem_msg_s;

    localparam int io_mem_msg_width_gp = $bits(bp_bedrock_io_mem_msg_s);

endpackage

// File: rtl/bp_fpga_host_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter,
// accepted level and a one-cycle pulse on each accepted rising edge.
module bp_fpga_host_debounce
    import bp_fpga_host_pkg::*;
#(
    parameter int cycles_p = debounce_cycles_gp
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int                  cnt_w_lp   = $clog2(cycles_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(cycles_p);

    logic                sync1_q, sync2_q;
    logic                last_q, last_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    // Count consecutive equal samples; accept the level once the run is long enough
    always_comb begin
        last_d  = sync2_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q != last_q) begin
            cnt_d = cnt_w_lp'(1);
        end else if (cnt_q != cnt_max_lp) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            level_d = last_q;
            rise_d  = last_q & ~level_q;
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            last_q  <= last_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/fpga_host_putchar_gen.sv
// Button-driven putchar generator for the fpga host io_cmd port: each
// debounced press issues one uncached byte write to the putchar address and
// then consumes the matching response.
// Optional response watchdog: define FPGA_HOST_PUTCHAR_TIMEOUT_EN.
module fpga_host_putchar_gen
    import bp_fpga_host_pkg::*;
#(
    parameter bp_params_e  bp_params_p       = e_bp_default_cfg,
    parameter int          debounce_cycles_p = debounce_cycles_gp,
    parameter logic [63:0] putchar_addr_p    = putchar_base_addr_gp,
    parameter logic [7:0]  init_byte_p       = 8'h30,
    parameter int          timeout_cycles_p  = 2**20
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   button_i,
    output bp_bedrock_io_mem_msg_s io_cmd_o,
    output logic                   io_cmd_v_o,
    input  logic                   io_cmd_ready_and_i,
    input  bp_bedrock_io_mem_msg_s io_resp_i,
    input  logic                   io_resp_v_i,
    output logic                   io_resp_yumi_o,
    output logic                   busy_o,
    output logic [15:0]            sent_count_o,
    output logic                   error_o
);

    send_state_e            state_q, state_d;
    logic [7:0]             byte_q, byte_d;
    logic [15:0]            count_q, count_d;
    logic                   pending_q, pending_d;
    logic                   error_q, error_d;
    logic                   btn_rise;
    logic                   resp_bad;
    logic                   timeout;
    bp_bedrock_io_mem_msg_s cmd_msg;

    logic unused_btn_level;
    logic unused_resp;
    logic unused_cfg;

    bp_fpga_host_debounce #(
        .cycles_p (debounce_cycles_p)
    ) debounce (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .raw_i     (button_i),
        .level_o   (unused_btn_level),
        .rise_o    (btn_rise)
    );

    assign unused_resp = ^{io_resp_i.header.payload, io_resp_i.header.subop,
                           io_resp_i.header.size, io_resp_i.data};
    assign unused_cfg  = (bp_params_p == e_bp_default_cfg);

    assign resp_bad = (io_resp_i.header.msg_type.mem != e_bedrock_mem_uc_wr)
                   || (io_resp_i.header.addr != putchar_addr_p[paddr_width_gp-1:0]);

`ifdef FPGA_HOST_PUTCHAR_TIMEOUT_EN
    localparam int wdog_w_lp = $clog2(timeout_cycles_p + 1);

    logic [wdog_w_lp-1:0] wdog_q, wdog_d;

    assign wdog_d  = (state_q == e_resp) ? wdog_q + 1'b1 : '0;
    assign timeout = (state_q == e_resp) && (wdog_q == wdog_w_lp'(timeout_cycles_p - 1));

    // Response watchdog, restarted on every entry into e_resp
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) wdog_q <= '0;
        else            wdog_q <= wdog_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_cycles_p != 0);
    assign timeout        = 1'b0;
`endif

    // Fixed putchar write; only the low data byte varies
    always_comb begin
        cmd_msg                       = '0;
        cmd_msg.header.msg_type.mem   = e_bedrock_mem_uc_wr;
        cmd_msg.header.subop          = e_bedrock_store;
        cmd_msg.header.addr           = putchar_addr_p[paddr_width_gp-1:0];
        cmd_msg.header.size           = e_bedrock_msg_size_1;
        cmd_msg.data[7:0]             = byte_q;
    end

    // Next-state, one-deep press queue, handshakes and response checking
    always_comb begin
        state_d        = state_q;
        byte_d         = byte_q;
        count_d        = count_q;
        pending_d      = pending_q | btn_rise;
        error_d        = error_q;
        io_resp_yumi_o = 1'b0;
        case (state_q)
            e_reset: state_d = e_ready;
            e_ready: begin
                if (pending_q) begin
                    state_d   = e_send;
                    pending_d = btn_rise;
                end
            end
            e_send: begin
                if (io_cmd_ready_and_i) begin
                    state_d = e_resp;
                    byte_d  = byte_q + 8'd1;
                end
            end
            e_resp: begin
                io_resp_yumi_o = io_resp_v_i & reset_n_i;
                if (io_resp_v_i) begin
                    state_d = e_ready;
                    count_d = count_q + 16'd1;
                    if (resp_bad) error_d = 1'b1;
                end else if (timeout) begin
                    state_d = e_ready;
                    error_d = 1'b1;
                end
            end
            default: state_d = e_reset;
        endcase
        // A response nobody asked for is left on the bus and flagged
        if (io_resp_v_i && (state_q != e_resp)) error_d = 1'b1;
    end

    // Control and data registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= e_reset;
            byte_q    <= init_byte_p;
            count_q   <= '0;
            pending_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            error_q   <= error_d;
        end
    end

    assign io_cmd_v_o   = reset_n_i & (state_q == e_send);
    assign io_cmd_o     = (state_q == e_send) ? cmd_msg : '0;
    assign busy_o       = (state_q == e_send) || (state_q == e_resp);
    assign sent_count_o = count_q;
    assign error_o      = error_q;

endmodule
